// File: rtl/sparse_weight_streamer.sv
// CSR sparse weight streamer: row pointer table + packed {index,value} store, both sync-read BRAM.
// Define SWS_BOUNDS_CHECK_EN to enable pointer/column bounds checking with a sticky err flag.
module sparse_weight_streamer #(
  parameter int NNZ_DEPTH   = 1024,
  parameter int NUM_ROWS    = 64,
  parameter int INDEX_WIDTH = 12,
  parameter int VALUE_WIDTH = 16,
  parameter int NUM_COLS    = 4096,
  parameter     NNZ_INIT_FILE = "",
  parameter     PTR_INIT_FILE = ""
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [$clog2(NUM_ROWS)-1:0]        req_row,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [INDEX_WIDTH-1:0]             out_idx,
  output logic [VALUE_WIDTH-1:0]             out_val,
  output logic                               out_last,
  output logic                               out_empty,
  output logic                               busy,
  input  logic                               wr_en,
  input  logic                               wr_sel,
  input  logic [$clog2(NNZ_DEPTH)-1:0]       wr_addr,
  input  logic [INDEX_WIDTH+VALUE_WIDTH-1:0] wr_data,
  output logic                               err
);
  localparam int AW  = $clog2(NNZ_DEPTH);
  localparam int PW  = AW + 1;
  localparam int RW  = $clog2(NUM_ROWS);
  localparam int PAW = $clog2(NUM_ROWS + 1);
  localparam int DW  = INDEX_WIDTH + VALUE_WIDTH;

  typedef enum logic [2:0] {IDLE, RDPTR0, RDPTR1, STREAM, EMPTY, DRAIN} state_t;

  logic [PW-1:0] ptr_mem [NUM_ROWS+1];
  logic [DW-1:0] nnz_mem [NNZ_DEPTH];

  state_t        state;
  logic [RW-1:0] row_r;
  logic [PW-1:0] start_r, end_r, nxt_r, ptr_q;
  logic [DW-1:0] nnz_q, sk_data;
  logic          rd_pend, pend_last, sk_valid, sk_last;

  logic           wr_ok, accept, pop, bad_ptr, is_empty, rd_last, ptr_fwd;
  logic [1:0]     occ;
  logic           ptr_rd_en, nnz_rd_en;
  logic [PAW-1:0] ptr_rd_addr;
  logic [PW-1:0]  nnz_rd_addr, end_cur;

  assign wr_ok  = wr_en & ~busy;
  assign accept = (state == IDLE) & req_valid & req_ready;
  assign pop    = out_valid & out_ready;
  // Occupancy the skid buffer will have after this edge, counting the read in flight.
  assign occ    = 2'(out_valid) + 2'(sk_valid) + 2'(rd_pend) - 2'(pop);

`ifdef SWS_BOUNDS_CHECK_EN
  assign bad_ptr = (ptr_q < start_r) || (ptr_q > PW'(NNZ_DEPTH));
`else
  assign bad_ptr = 1'b0;
`endif
  assign is_empty = (ptr_q == start_r) || bad_ptr;
  assign end_cur  = (state == RDPTR1) ? ptr_q : end_r;
  assign rd_last  = (nnz_rd_addr == end_cur - PW'(1));
  // A pointer write landing in the accept cycle must be seen by that request's first read.
  assign ptr_fwd  = accept & wr_ok & wr_sel & (int'(wr_addr) == int'(req_row));

  always_comb begin
    ptr_rd_en   = 1'b0;
    ptr_rd_addr = PAW'(req_row);
    nnz_rd_en   = 1'b0;
    nnz_rd_addr = nxt_r;
    case (state)
      IDLE:   ptr_rd_en = accept;
      RDPTR0: begin
        ptr_rd_en   = 1'b1;
        ptr_rd_addr = PAW'(row_r) + PAW'(1);
      end
      RDPTR1: begin
        nnz_rd_en   = ~is_empty;
        nnz_rd_addr = start_r;
      end
      STREAM: nnz_rd_en = (occ < 2'd2);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok && wr_sel && int'(wr_addr) <= NUM_ROWS)
      ptr_mem[PAW'(wr_addr)] <= wr_data[PW-1:0];
    if (ptr_rd_en)
      ptr_q <= ptr_fwd ? wr_data[PW-1:0] : ptr_mem[ptr_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !wr_sel)
      nnz_mem[wr_addr] <= wr_data;
    if (nnz_rd_en)
      nnz_q <= nnz_mem[nnz_rd_addr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_empty <= 1'b0;
      out_idx   <= '0;
      out_val   <= '0;
      sk_valid  <= 1'b0;
      sk_last   <= 1'b0;
      sk_data   <= '0;
      rd_pend   <= 1'b0;
      pend_last <= 1'b0;
      row_r     <= '0;
      start_r   <= '0;
      end_r     <= '0;
      nxt_r     <= '0;
    end else begin
      rd_pend   <= nnz_rd_en;
      pend_last <= nnz_rd_en & rd_last;

      // Head register drives out_*; sk_* holds the beat that arrives while the head is stalled.
      if (!out_valid || pop) begin
        if (sk_valid) begin
          out_valid <= 1'b1;
          {out_idx, out_val} <= sk_data;
          out_last  <= sk_last;
          out_empty <= 1'b0;
          sk_valid  <= rd_pend;
          sk_data   <= nnz_q;
          sk_last   <= pend_last;
        end else if (rd_pend) begin
          out_valid <= 1'b1;
          {out_idx, out_val} <= nnz_q;
          out_last  <= pend_last;
          out_empty <= 1'b0;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (rd_pend) begin
        sk_valid <= 1'b1;
        sk_data  <= nnz_q;
        sk_last  <= pend_last;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            row_r     <= req_row;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state     <= RDPTR0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        RDPTR0: begin
          start_r <= ptr_q;
          state   <= RDPTR1;
        end
        RDPTR1: begin
          end_r <= ptr_q;
          if (is_empty) begin
            out_valid <= 1'b1;
            out_empty <= 1'b1;
            out_last  <= 1'b1;
            out_idx   <= '0;
            out_val   <= '0;
            state     <= EMPTY;
          end else begin
            nxt_r <= start_r + PW'(1);
            state <= rd_last ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (nnz_rd_en) begin
            nxt_r <= nxt_r + PW'(1);
            if (rd_last) state <= DRAIN;
          end
        end
        EMPTY, DRAIN: begin
          if (pop && out_last) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SWS_BOUNDS_CHECK_EN
  localparam logic [INDEX_WIDTH:0] COL_LIM = (INDEX_WIDTH+1)'(NUM_COLS);
  always_ff @(posedge clk) begin
    if (!rst_n)
      err <= 1'b0;
    else if ((state == RDPTR1 && bad_ptr) ||
             (out_valid && !out_empty && {1'b0, out_idx} >= COL_LIM))
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sparse_weight_streamer.sv
// Scoreboard bench for sparse_weight_streamer: expected beats queued at request time, popped on handshake.
module tb_sparse_weight_streamer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [5:0]  req_row = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [11:0] out_idx;
  logic [15:0] out_val;
  logic        out_last, out_empty, busy;
  logic        wr_en = 1'b0, wr_sel = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [27:0] wr_data = '0;
  logic        err;

  sparse_weight_streamer #(.NNZ_DEPTH(1024), .NUM_ROWS(64), .INDEX_WIDTH(12),
                           .VALUE_WIDTH(16), .NUM_COLS(4096)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_val(out_val), .out_last(out_last),
    .out_empty(out_empty), .busy(busy), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .err(err));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] idx;
    logic [15:0] val;
    logic        last;
    logic        empty;
  } beat_t;

  beat_t sb[$];
  int    hs_q[$];
  int    cyc = 0;
  int    errors = 0, checks = 0;
  logic  stall_prev = 1'b0;
  beat_t held;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: stability while stalled, then scoreboard compare on each handshake.
  always @(negedge clk) begin
    beat_t got;
    got = '{idx: out_idx, val: out_val, last: out_last, empty: out_empty};
    if (rst_n && stall_prev) begin
      checks++;
      if (!out_valid || got !== held) begin
        errors++;
        $display("FAIL stall_hold: got valid=%0b beat=%h, required valid=1 beat=%h", out_valid, got, held);
      end
    end
    stall_prev = rst_n && out_valid && !out_ready;
    held = got;
    if (rst_n && out_valid && out_ready) begin
      hs_q.push_back(cyc + 1);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got %h, required none", got);
      end else begin
        beat_t exp;
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL beat: got idx=%0d val=%h last=%0b empty=%0b, required idx=%0d val=%h last=%0b empty=%0b",
                   got.idx, got.val, got.last, got.empty, exp.idx, exp.val, exp.last, exp.empty);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input int addr, input int data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 10'(addr); wr_data = 28'(data);
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic send_req(input int row, output int t);
    req_valid = 1'b1; req_row = 6'(row);
    step(1);
    t = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      step(1);
      n++;
    end
    checks++;
    if (sb.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_timeout: got pending=%0d busy=%0b, required 0 and 0", name, sb.size(), busy);
    end
  endtask

  task automatic push_row0();
    sb.push_back('{12'd7,  16'h0011, 1'b0, 1'b0});
    sb.push_back('{12'd9,  16'h0022, 1'b0, 1'b0});
    sb.push_back('{12'd40, 16'h0033, 1'b1, 1'b0});
  endtask

  task automatic push_row2();
    sb.push_back('{12'd2, 16'h0044, 1'b0, 1'b0});
    sb.push_back('{12'd5, 16'h0055, 1'b1, 1'b0});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    checks++;
    if ({req_ready, out_valid, busy, err, out_last, out_empty} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/vld/busy/err/last/empty=%b, required 000000",
               {req_ready, out_valid, busy, err, out_last, out_empty});
    end
    checks++;
    if ({out_idx, out_val} !== 28'd0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0", {out_idx, out_val});
    end
    rst_n = 1'b1;
    step(2);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: got %0b, required 1", req_ready);
    end
  endtask

  task automatic load_tables();
    int ptrs[4] = '{0, 3, 3, 5};
    int nnz[5]  = '{(7 << 16) | 'h11, (9 << 16) | 'h22, (40 << 16) | 'h33,
                    (2 << 16) | 'h44, (5 << 16) | 'h55};
    foreach (ptrs[i]) wr(1'b1, i, ptrs[i]);
    foreach (nnz[i])  wr(1'b0, i, nnz[i]);
  endtask

  task automatic test_row_latency();
    int t, bl = -1, n = 0;
    hs_q.delete();
    push_row0();
    send_req(0, t);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept: got %0b, required 1", busy);
    end
    while ((sb.size() != 0 || busy) && n < 40) begin
      step(1);
      n++;
      if (!busy && bl < 0) bl = cyc;
    end
    checks++;
    if (hs_q.size() != 3) begin
      errors++;
      $display("FAIL row0_count: got %0d beats, required 3", hs_q.size());
    end else begin
      checks++;
      if (hs_q[0] != t + 4 || hs_q[2] != t + 6) begin
        errors++;
        $display("FAIL row0_timing: got first=%0d last=%0d, required %0d %0d", hs_q[0] - t, hs_q[2] - t, 4, 6);
      end
    end
    checks++;
    if (bl != t + 6) begin
      errors++;
      $display("FAIL busy_drop: got %0d, required %0d", bl - t, 6);
    end
  endtask

  task automatic test_empty_row();
    int t;
    hs_q.delete();
    sb.push_back('{12'd0, 16'h0000, 1'b1, 1'b1});
    send_req(1, t);
    wait_done("empty");
    step(1);
    checks++;
    if (hs_q.size() != 1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL empty_row: got beats=%0d ready=%0b, required 1 and 1", hs_q.size(), req_ready);
    end
  endtask

  task automatic test_backpressure();
    int t, k = 0;
    logic [3:0] pat = 4'b1001;
    hs_q.delete();
    push_row0();
    out_ready = pat[0];
    send_req(0, t);
    while ((sb.size() != 0 || busy) && k < 60) begin
      k++;
      out_ready = pat[k % 4];
      step(1);
    end
    out_ready = 1'b1;
    checks++;
    if (hs_q.size() != 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_row0: got beats=%0d pending=%0d, required 3 and 0", hs_q.size(), sb.size());
    end
  endtask

  task automatic test_write_ignored();
    int t;
    hs_q.delete();
    push_row0();
    send_req(0, t);
    step(1);
    wr(1'b1, 2, 0);
    wait_done("wr_busy_row0");
    push_row2();
    send_req(2, t);
    wait_done("wr_busy_row2");
    checks++;
    if (hs_q.size() != 5) begin
      errors++;
      $display("FAIL write_ignored: got beats=%0d, required 5", hs_q.size());
    end
  endtask

  task automatic test_write_with_req();
    int t;
    hs_q.delete();
    sb.push_back('{12'd5, 16'h0055, 1'b1, 1'b0});
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 10'd2; wr_data = 28'd4;
    send_req(2, t);
    wr_en = 1'b0;
    wait_done("wr_same_cycle");
    checks++;
    if (hs_q.size() != 1) begin
      errors++;
      $display("FAIL write_with_req: got beats=%0d, required 1", hs_q.size());
    end
    wr(1'b1, 2, 3);
  endtask

  task automatic test_reset_midstream();
    int t, n = 0;
    hs_q.delete();
    push_row0();
    send_req(0, t);
    while (hs_q.size() == 0 && n < 20) begin
      step(1);
      n++;
    end
    rst_n = 1'b0;
    step(1);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midstream_reset: got valid=%0b busy=%0b, required 0 0", out_valid, busy);
    end
    sb.delete();
    rst_n = 1'b1;
    step(2);
    hs_q.delete();
    push_row2();
    send_req(2, t);
    wait_done("after_reset");
    checks++;
    if (hs_q.size() != 2) begin
      errors++;
      $display("FAIL after_reset_row2: got beats=%0d, required 2", hs_q.size());
    end
  endtask

`ifdef SWS_BOUNDS_CHECK_EN
  task automatic test_bounds();
    int t;
    wr(1'b1, 0, 4);
    wr(1'b1, 1, 2);
    sb.push_back('{12'd0, 16'h0000, 1'b1, 1'b1});
    send_req(0, t);
    wait_done("bounds");
    step(4);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %0b, required 1", err);
    end
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: got %0b, required 0", err);
    end
    step(2);
    wr(1'b1, 0, 0);
    wr(1'b1, 1, 3);
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1);
    test_reset();
    load_tables();
    test_row_latency();
    test_empty_row();
    test_backpressure();
    test_write_ignored();
    test_write_with_req();
    test_reset_midstream();
`ifdef SWS_BOUNDS_CHECK_EN
    test_bounds();
`endif
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
